// File: rtl/matrix_tile_sequencer.sv
// matrix_tile_sequencer
//   Walks a blocked matrix multiply C[n x p] = A[n x m] * B[m x p] in 3x3 tiles.
//   It issues one tile command per valid/ready handshake in this order:
//   i outer, j middle, k inner. For each (i,j) it sends A(i,k) and B(k,j) for
//   every k, then C(i,j).
//
//   State table:
//     IDLE    | waiting for start; job inputs are latched when start is accepted
//     ISSUE_A | presenting READ_A of tile A(i,k)
//     ISSUE_B | presenting READ_B of tile B(k,j)
//     ISSUE_C | presenting WRITE_C of tile C(i,j)
//     FINISH  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   start                   job request, sampled only in IDLE
//   n, m, p                 matrix dimensions, latched on start
//   b_base, c_base          word bases of B and C (A is based at 0)
//   busy, done              job status
//   cmd_valid, cmd_ready    command handshake
//   cmd_op                  0=READ_A, 1=READ_B, 2=WRITE_C
//   cmd_addr, cmd_cols      tile top-left word address and row pitch
//   cmd_we                  write enable, set only for WRITE_C
//   acc_clear, acc_last     accumulator control flags for the MAC datapath
module matrix_tile_sequencer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] n,
    input  logic [ADDR_WIDTH-1:0] m,
    input  logic [ADDR_WIDTH-1:0] p,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [ADDR_WIDTH-1:0] cmd_cols,
    output logic                  cmd_we,
    output logic                  acc_clear,
    output logic                  acc_last
);

    localparam int W = ADDR_WIDTH;

    localparam logic [1:0] OP_READ_A  = 2'd0;
    localparam logic [1:0] OP_READ_B  = 2'd1;
    localparam logic [1:0] OP_WRITE_C = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        ISSUE_C,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [W-1:0] n_r, m_r, p_r, bb_r, cb_r;
    logic [W-1:0] n_nx, m_nx, p_nx, bb_nx, cb_nx;
    logic [W-1:0] i_r, j_r, k_r;
    logic [W-1:0] i_nx, j_nx, k_nx;

    // Running address offsets, updated by addition as the indices step so no
    // multiplier is needed: k3 = 3k, kp3 = 3kp, j3 = 3j, arow = 3im, ip3 = 3ip.
    logic [W-1:0] k3_r, kp3_r, j3_r, arow_r, ip3_r;
    logic [W-1:0] k3_nx, kp3_nx, j3_nx, arow_nx, ip3_nx;

    logic [W:0]   nt, mt, pt, mt_nx;
    logic [W-1:0] m3, p3;

    logic [1:0]   op_nx;
    logic [W-1:0] addr_nx, cols_nx;
    logic         we_nx, clr_nx, last_nx;

    logic         hs;

    function automatic logic [W:0] tiles(input logic [W-1:0] x);
        logic [W:0] t;
        t = {1'b0, x} + (W+1)'(2);
        return t / (W+1)'(3);
    endfunction

    assign nt = tiles(n_r);
    assign mt = tiles(m_r);
    assign pt = tiles(p_r);
    assign m3 = m_r + {m_r[W-2:0], 1'b0};
    assign p3 = p_r + {p_r[W-2:0], 1'b0};

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign cmd_valid = (state == ISSUE_A) || (state == ISSUE_B) || (state == ISSUE_C);
    assign hs        = cmd_valid && cmd_ready;

    always_comb begin
        state_nx = state;
        n_nx     = n_r;
        m_nx     = m_r;
        p_nx     = p_r;
        bb_nx    = bb_r;
        cb_nx    = cb_r;
        i_nx     = i_r;
        j_nx     = j_r;
        k_nx     = k_r;
        k3_nx    = k3_r;
        kp3_nx   = kp3_r;
        j3_nx    = j3_r;
        arow_nx  = arow_r;
        ip3_nx   = ip3_r;

        case (state)
            IDLE: begin
                if (start) begin
                    n_nx    = n;
                    m_nx    = m;
                    p_nx    = p;
                    bb_nx   = b_base;
                    cb_nx   = c_base;
                    i_nx    = '0;
                    j_nx    = '0;
                    k_nx    = '0;
                    k3_nx   = '0;
                    kp3_nx  = '0;
                    j3_nx   = '0;
                    arow_nx = '0;
                    ip3_nx  = '0;
                    if (n == '0 || m == '0 || p == '0) state_nx = FINISH;
                    else                               state_nx = ISSUE_A;
                end
            end
            ISSUE_A: begin
                if (hs) state_nx = ISSUE_B;
            end
            ISSUE_B: begin
                if (hs) begin
                    if (({1'b0, k_r} + (W+1)'(1)) < mt) begin
                        k_nx     = k_r + W'(1);
                        k3_nx    = k3_r + W'(3);
                        kp3_nx   = kp3_r + p3;
                        state_nx = ISSUE_A;
                    end else begin
                        state_nx = ISSUE_C;
                    end
                end
            end
            ISSUE_C: begin
                if (hs) begin
                    k_nx   = '0;
                    k3_nx  = '0;
                    kp3_nx = '0;
                    if (({1'b0, j_r} + (W+1)'(1)) < pt) begin
                        j_nx     = j_r + W'(1);
                        j3_nx    = j3_r + W'(3);
                        state_nx = ISSUE_A;
                    end else if (({1'b0, i_r} + (W+1)'(1)) < nt) begin
                        j_nx     = '0;
                        j3_nx    = '0;
                        i_nx     = i_r + W'(1);
                        arow_nx  = arow_r + m3;
                        ip3_nx   = ip3_r + p3;
                        state_nx = ISSUE_A;
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Command fields are derived from the next state and next indices and
        // then registered. While a command stalls nothing changes, so the
        // registered fields stay stable without extra hold logic.
        mt_nx   = tiles(m_nx);
        op_nx   = OP_READ_A;
        addr_nx = '0;
        cols_nx = '0;
        we_nx   = 1'b0;
        clr_nx  = 1'b0;
        last_nx = 1'b0;
        case (state_nx)
            ISSUE_A: begin
                op_nx   = OP_READ_A;
                addr_nx = arow_nx + k3_nx;
                cols_nx = m_nx;
                clr_nx  = (k_nx == '0);
            end
            ISSUE_B: begin
                op_nx   = OP_READ_B;
                addr_nx = bb_nx + kp3_nx + j3_nx;
                cols_nx = p_nx;
                last_nx = (({1'b0, k_nx} + (W+1)'(1)) == mt_nx);
            end
            ISSUE_C: begin
                op_nx   = OP_WRITE_C;
                addr_nx = cb_nx + ip3_nx + j3_nx;
                cols_nx = p_nx;
                we_nx   = 1'b1;
            end
            default: begin
                op_nx = OP_READ_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            n_r       <= '0;
            m_r       <= '0;
            p_r       <= '0;
            bb_r      <= '0;
            cb_r      <= '0;
            i_r       <= '0;
            j_r       <= '0;
            k_r       <= '0;
            k3_r      <= '0;
            kp3_r     <= '0;
            j3_r      <= '0;
            arow_r    <= '0;
            ip3_r     <= '0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_cols  <= '0;
            cmd_we    <= 1'b0;
            acc_clear <= 1'b0;
            acc_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            n_r       <= n_nx;
            m_r       <= m_nx;
            p_r       <= p_nx;
            bb_r      <= bb_nx;
            cb_r      <= cb_nx;
            i_r       <= i_nx;
            j_r       <= j_nx;
            k_r       <= k_nx;
            k3_r      <= k3_nx;
            kp3_r     <= kp3_nx;
            j3_r      <= j3_nx;
            arow_r    <= arow_nx;
            ip3_r     <= ip3_nx;
            cmd_op    <= op_nx;
            cmd_addr  <= addr_nx;
            cmd_cols  <= cols_nx;
            cmd_we    <= we_nx;
            acc_clear <= clr_nx;
            acc_last  <= last_nx;
        end
    end

endmodule
